// File: rtl/vram_pkg.sv
// Frame-buffer geometry for the VGA scan-out path.
// The 200x150 frame buffer is upscaled 4x to an 800x600 screen.
package vram_pkg;
    localparam int unsigned H_ACT   = 800;
    localparam int unsigned V_ACT   = 600;
    localparam int unsigned SCL     = 2;
    localparam int unsigned FB_W    = H_ACT >> SCL;
    localparam int unsigned FB_H    = V_ACT >> SCL;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned AW      = 15;
    localparam int unsigned DW      = 12;
endpackage

// File: rtl/vram_scan_addr.sv
// Screen position tracking and display read-slot / read-address generation.
// Tracks x/y from hen/ven edges and walks the frame-buffer row base without a multiplier.
module vram_scan_addr
    import vram_pkg::*;
(
    input  logic          pclk,
    input  logic          rstn,
    input  logic          hen,
    input  logic          ven,
    output logic          de,
    output logic          rd_slot,
    output logic [AW-1:0] rd_addr
);

    logic [9:0]    x;
    logic [9:0]    y;
    logic [AW-1:0] row_base;
    logic          synced;
    logic          hen_d;
    logic          hen_fall;

    assign hen_fall = hen_d & ~hen;
    assign de       = hen & ven & synced;
    assign rd_slot  = de & (x[SCL-1:0] == '0);
    assign rd_addr  = row_base + AW'(x >> SCL);

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            synced   <= 1'b0;
            hen_d    <= 1'b0;
        end else begin
            hen_d <= hen;
            // Waiting for vblank keeps a mid-frame reset from scanning a torn frame.
            if (!ven) begin
                synced <= 1'b1;
            end
            if (!hen) begin
                x <= '0;
            end else if (de) begin
                x <= x + 10'd1;
            end
            if (!ven) begin
                y        <= '0;
                row_base <= '0;
            end else if (hen_fall) begin
                y <= y + 10'd1;
                // Last screen line of a frame-buffer row: step to the next row.
                if (y[SCL-1:0] == '1) begin
                    row_base <= row_base + AW'(FB_W);
                end
            end
        end
    end

endmodule

// File: rtl/vram_scan_arbiter.sv
// VRAM port arbiter between display scan-out and a drawing unit, plus RGB output pipeline.
// Display reads own their slot; the writer takes any other cycle.
module vram_scan_arbiter
    import vram_pkg::*;
(
    input  logic          pclk,
    input  logic          rstn,
    input  logic          hen,
    input  logic          ven,
    input  logic          hs,
    input  logic          vs,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic          hs_o,
    output logic          vs_o
);

    logic          de;
    logic          rd_slot;
    logic [AW-1:0] rd_addr;
    logic          ld_d1;
    logic          de_d1;
    logic          hs_d1;
    logic          vs_d1;
    logic [DW-1:0] hold;

    vram_scan_addr u_scan (
        .pclk    (pclk),
        .rstn    (rstn),
        .hen     (hen),
        .ven     (ven),
        .de      (de),
        .rd_slot (rd_slot),
        .rd_addr (rd_addr)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (rd_slot) begin
            mem_addr = rd_addr;
        end else if (wr_req) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            wr_ack    = 1'b1;
            // Out-of-range writes are acknowledged but never reach the RAM.
            mem_we    = (wr_addr < AW'(FB_SIZE));
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            ld_d1 <= 1'b0;
            de_d1 <= 1'b0;
            hs_d1 <= 1'b0;
            vs_d1 <= 1'b0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            hold  <= '0;
            rgb   <= '0;
        end else begin
            ld_d1 <= rd_slot;
            de_d1 <= de;
            hs_d1 <= hs;
            vs_d1 <= vs;
            hs_o  <= hs_d1;
            vs_o  <= vs_d1;
            if (ld_d1) begin
                hold <= mem_rdata;
            end
            // The fresh read covers its own pixel; the next three reuse the held copy.
            rgb <= de_d1 ? (ld_d1 ? mem_rdata : hold) : '0;
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a VRAM model and an expected-output scoreboard.
module tb_vram_scan_arbiter;
    import vram_pkg::*;

    typedef struct packed {
        logic [DW-1:0] rgb;
        logic          hs;
        logic          vs;
    } exp_t;

    logic          pclk = 1'b0;
    logic          rstn;
    logic          hen, ven, hs, vs;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rgb;
    logic          hs_o, vs_o;

    logic [DW-1:0] vram [0:(1<<AW)-1];
    logic [DW-1:0] img  [0:(1<<AW)-1];
    exp_t          q [$];

    int            vectors = 0;
    int            miscompares = 0;
    logic          synced_m;
    logic          wr_on;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    int            wr_line;
    int            rst_line;

    always #5 pclk = ~pclk;

    vram_scan_arbiter dut (
        .pclk      (pclk),
        .rstn      (rstn),
        .hen       (hen),
        .ven       (ven),
        .hs        (hs),
        .vs        (vs),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rgb       (rgb),
        .hs_o      (hs_o),
        .vs_o      (vs_o)
    );

    // Synchronous single-port VRAM: read data one cycle after the address.
    initial begin
        for (int i = 0; i < (1 << AW); i++) vram[i] <= DW'(i);
    end

    always @(posedge pclk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel clock: drive at negedge, check the port mux, then score the delayed outputs.
    task automatic cyc(input logic h, input logic v, input logic hsi, input logic vsi,
                       input int xi, input int li);
        logic        de_m, rd_m, ack_m, we_m;
        logic [31:0] a;
        exp_t        e;
        hen = h; ven = v; hs = hsi; vs = vsi;
        wr_req = wr_on; wr_addr = wr_a; wr_data = wr_d;
        de_m  = h & v & synced_m;
        rd_m  = de_m && (xi % 4 == 0);
        a     = 32'((li / 4) * 200 + xi / 4);
        ack_m = wr_on && !rd_m;
        we_m  = ack_m && (wr_a < AW'(FB_SIZE));
        #1;
        chk("wr_ack", 32'(wr_ack), 32'(ack_m));
        chk("mem_we", 32'(mem_we), 32'(we_m));
        if (rd_m) begin
            chk("rd_addr", 32'(mem_addr), a);
        end else if (wr_on) begin
            chk("wr_addr", 32'(mem_addr), 32'(wr_a));
            chk("wr_data", 32'(mem_wdata), 32'(wr_d));
        end
        if (we_m) img[wr_a] = wr_d;
        e.rgb = de_m ? img[a[AW-1:0]] : '0;
        e.hs  = hsi;
        e.vs  = vsi;
        q.push_back(e);
        if (!v) synced_m = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("rgb", 32'(rgb), 32'(e.rgb));
            chk("hs_o", 32'(hs_o), 32'(e.hs));
            chk("vs_o", 32'(vs_o), 32'(e.vs));
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_hs_o", 32'(hs_o), 32'd0);
        chk("rst_vs_o", 32'(vs_o), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge pclk);
        @(negedge pclk);
        rstn = 1'b1;
        q.delete();
        synced_m = 1'b0;
    endtask

    task automatic scan_line(input int li, input int nact, input logic v, input logic vsi);
        if (v && li == wr_line) begin
            wr_on = 1'b1; wr_a = AW'(5000); wr_d = 12'h388;
        end
        for (int xi = 0; xi < nact; xi++) begin
            if (v && li == rst_line && xi == 4) do_reset();
            cyc(1'b1, v, 1'b0, vsi, xi, li);
        end
        for (int b = 0; b < 6; b++) cyc(1'b0, v, (b == 2 || b == 3), vsi, 0, li);
        if (v && li == wr_line) wr_on = 1'b0;
    endtask

    // Full-width lines only where listed; the rest use short hen bursts to keep runtime low.
    task automatic frame(input int f0, input int f1, input int f2);
        for (int li = 0; li < int'(V_ACT); li++)
            scan_line(li, (li == f0 || li == f1 || li == f2) ? int'(H_ACT) : 8, 1'b1, 1'b0);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) scan_line(0, 8, 1'b0, (i == 1 || i == 2));
    endtask

    initial begin
        rstn = 1'b0;
        hen = 1'b0; ven = 1'b0; hs = 1'b0; vs = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        wr_on = 1'b0; wr_a = '0; wr_d = '0;
        wr_line = -1; rst_line = -1; synced_m = 1'b0;
        for (int i = 0; i < (1 << AW); i++) img[i] = DW'(i);
        repeat (3) @(negedge pclk);
        #1;
        chk("init_rgb", 32'(rgb), 32'd0);
        chk("init_hs_o", 32'(hs_o), 32'd0);
        chk("init_vs_o", 32'(vs_o), 32'd0);
        chk("init_wr_ack", 32'(wr_ack), 32'd0);
        chk("init_mem_we", 32'(mem_we), 32'd0);
        chk("init_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge pclk);
        rstn = 1'b1;

        vblank(4);
        wr_line = 4;
        frame(0, 4, 599);
        wr_line = -1;

        // Blanking writes: one out of range, one to fb pixel 0.
        wr_on = 1'b1; wr_a = AW'(30000); wr_d = 12'hABC;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        wr_a = '0; wr_d = 12'h0F0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        wr_on = 1'b0;
        vblank(4);

        rst_line = 300;
        frame(-1, -1, -1);
        rst_line = -1;
        vblank(4);
        frame(-1, -1, -1);
        vblank(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
